io_scan_sequencer: RTL

IO_SCAN_SEQUENCER -- requirements
Module: io_scan_sequencer

---
 rtl/io_scan_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/io_scan_sequencer.sv
// ----------------------------------------------------------------------------
// io_scan_sequencer
// Runs a fixed seven-step scan over an 8-bit I/O bus: drives the TH lines of
// port 0x3F low, reads 0xDC/0xDD, drives TH high, reads 0xDC/0xDD again, then
// returns all pins to input. The four read bytes are published together on
// RESULT with a one-clock DONE pulse.
//
// Ports
//   MCLK      in   clock, rising edge
//   RESET     in   asynchronous reset, active low
//   START     in   request one scan (sampled only while idle)
//   BUSGNT    in   bus grant
//   BUSREQ    out  bus request
//   ADDRESS   out  I/O port address (0x00 outside bus cycles)
//   DATA_o    out  write data (0x00 outside write cycles)
//   DATA_d    out  data bus direction, 0 = this block drives
//   DATA_i    in   read data
//   IORQ/RD/WR out active-low bus strobes
//   BUSY      out  scan in progress
//   DONE      out  one-clock pulse, RESULT freshly updated
//   RESULT    out  {DD_thhigh, DC_thhigh, DD_thlow, DC_thlow}
// ----------------------------------------------------------------------------
module io_scan_sequencer #(
   parameter int unsigned STROBE = 3,
   parameter int unsigned SETTLE = 16
) (
   input  logic        MCLK,
   input  logic        RESET,
   input  logic        START,
   input  logic        BUSGNT,
   output logic        BUSREQ,
   output logic [7:0]  ADDRESS,
   output logic [7:0]  DATA_o,
   output logic        DATA_d,
   input  logic [7:0]  DATA_i,
   output logic        IORQ,
   output logic        RD,
   output logic        WR,
   output logic        BUSY,
   output logic        DONE,
   output logic [31:0] RESULT
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAITGNT,
      ST_ADDR,
      ST_STRB,
      ST_RECOV,
      ST_SETTLE,
      ST_FIN
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  step_q, step_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] shadow_q, shadow_d;
   logic [31:0] result_q, result_d;

   // Bus operation selected by the current step
   logic        op_wr;
   logic [7:0]  op_addr;
   logic [7:0]  op_wdata;

   always_comb begin
      op_wr    = 1'b0;
      op_addr  = 8'h00;
      op_wdata = 8'h00;
      unique case (step_q)
         3'd0:    begin op_wr = 1'b1; op_addr = 8'h3F; op_wdata = 8'h55; end
         3'd1:    op_addr = 8'hDC;
         3'd2:    op_addr = 8'hDD;
         3'd3:    begin op_wr = 1'b1; op_addr = 8'h3F; op_wdata = 8'hF5; end
         3'd4:    op_addr = 8'hDC;
         3'd5:    op_addr = 8'hDD;
         3'd6:    begin op_wr = 1'b1; op_addr = 8'h3F; op_wdata = 8'hFF; end
         default: ;
      endcase
   end

   // State register
   always_ff @(posedge MCLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= ST_IDLE;
         step_q   <= '0;
         cnt_q    <= '0;
         shadow_q <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         result_q <= result_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      result_d = result_q;
      unique case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d = ST_WAITGNT;
               step_d  = '0;
            end
         end
         ST_WAITGNT: begin
            if (BUSGNT) state_d = ST_ADDR;
         end
         ST_ADDR: begin
            state_d = ST_STRB;
            cnt_d   = 8'(STROBE - 1);
         end
         ST_STRB: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_RECOV;
               // Read data is sampled on the last strobe clock
               if (!op_wr) begin
                  unique case (step_q)
                     3'd1:    shadow_d[7:0]   = DATA_i;
                     3'd2:    shadow_d[15:8]  = DATA_i;
                     3'd4:    shadow_d[23:16] = DATA_i;
                     3'd5:    shadow_d[31:24] = DATA_i;
                     default: ;
                  endcase
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_RECOV: begin
            if (step_q == 3'd6) begin
               // RESULT is loaded on entry to FIN so it is valid while DONE is high
               state_d  = ST_FIN;
               result_d = shadow_q;
            end else begin
               step_d = step_q + 3'd1;
               // Settling needs no bus, so the grant is only checked when it ends
               if ((step_q == 3'd0 || step_q == 3'd3) && (SETTLE != 0)) begin
                  state_d = ST_SETTLE;
                  cnt_d   = 8'(SETTLE - 1);
               end else if (BUSGNT) begin
                  state_d = ST_ADDR;
               end else begin
                  state_d = ST_WAITGNT;
               end
            end
         end
         ST_SETTLE: begin
            if (cnt_q == 8'd0) begin
               state_d = BUSGNT ? ST_ADDR : ST_WAITGNT;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode
   always_comb begin
      BUSREQ  = 1'b0;
      ADDRESS = 8'h00;
      DATA_o  = 8'h00;
      DATA_d  = 1'b1;
      IORQ    = 1'b1;
      RD      = 1'b1;
      WR      = 1'b1;
      BUSY    = 1'b1;
      DONE    = 1'b0;
      unique case (state_q)
         ST_IDLE: BUSY = 1'b0;
         ST_WAITGNT, ST_SETTLE: BUSREQ = 1'b1;
         ST_ADDR, ST_STRB, ST_RECOV: begin
            BUSREQ  = 1'b1;
            ADDRESS = op_addr;
            if (op_wr) begin
               DATA_o = op_wdata;
               DATA_d = 1'b0;
            end
            if (state_q == ST_STRB) begin
               IORQ = 1'b0;
               if (op_wr) WR = 1'b0;
               else       RD = 1'b0;
            end
         end
         ST_FIN: DONE = 1'b1;
         default: BUSY = 1'b0;
      endcase
   end

   assign RESULT = result_q;

endmodule
